// File: rtl/tmr_voter_scrub_if.sv
// Bus bundle for the TMR voter: three redundant channels plus clear in,
// voted result and health status out.
interface tmr_voter_scrub_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] c_in;
    logic             in_valid;
    logic             clr;
    logic [WIDTH-1:0] vote_out;
    logic             out_valid;
    logic             mismatch;
    logic             uncorrectable;
    logic [2:0]       fault_ch;
    logic             degraded;
    logic [CNT_W-1:0] err_count;

    modport master (
        output a_in, b_in, c_in, in_valid, clr,
        input  vote_out, out_valid, mismatch, uncorrectable, fault_ch, degraded, err_count
    );

    modport slave (
        input  a_in, b_in, c_in, in_valid, clr,
        output vote_out, out_valid, mismatch, uncorrectable, fault_ch, degraded, err_count
    );
endinterface

// File: rtl/tmr_voter_scrub.sv
// Two-stage WIDTH-bit TMR majority voter with per-channel dissent tracking;
// a persistently dissenting channel is latched failed and excluded.
module tmr_voter_scrub #(
    parameter int WIDTH   = 8,
    parameter int CNT_W   = 8,
    parameter int PERSIST = 4
) (
    input  logic            clock,
    input  logic            reset,
    tmr_voter_scrub_if.slave bus
);
    localparam int SW = $clog2(PERSIST + 1);

    logic [WIDTH-1:0] ch_reg [3];
    logic             v1_reg;

    logic [WIDTH-1:0] vote_reg;
    logic             out_valid_reg;
    logic             mismatch_reg;
    logic             unc_reg;
    logic [2:0]       fault_reg;
    logic [CNT_W-1:0] err_reg;
    logic [SW-1:0]    streak_reg [3];

    logic [WIDTH-1:0] maj;
    logic [WIDTH-1:0] h0;
    logic [WIDTH-1:0] h1;
    logic [WIDTH-1:0] vote_next;
    logic             mism_next;
    logic             unc_next;
    logic [2:0]       dissent;
    logic [2:0]       reach;
    logic [2:0]       fail_sel;
    logic [SW-1:0]    streak_inc [3];
    logic             degraded_w;

    // Stage 1: data holds on invalid cycles, valid bit always follows input.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) ch_reg[i] <= '0;
            v1_reg <= 1'b0;
        end else begin
            v1_reg <= bus.in_valid;
            if (bus.in_valid) begin
                ch_reg[0] <= bus.a_in;
                ch_reg[1] <= bus.b_in;
                ch_reg[2] <= bus.c_in;
            end
        end
    end

    assign maj        = (ch_reg[0] & ch_reg[1]) | (ch_reg[1] & ch_reg[2]) | (ch_reg[0] & ch_reg[2]);
    assign degraded_w = |fault_reg;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            assign dissent[gi]    = (ch_reg[gi] != maj);
            assign streak_inc[gi] = streak_reg[gi] + SW'(1);
            assign reach[gi]      = dissent[gi] && (streak_inc[gi] == SW'(PERSIST));
        end
    endgenerate

    // Lowest index wins when several channels cross the threshold together.
    assign fail_sel = reach[0] ? 3'b001 :
                      reach[1] ? 3'b010 :
                      reach[2] ? 3'b100 : 3'b000;

    always_comb begin
        h0 = ch_reg[0];
        h1 = ch_reg[1];
        if (fault_reg[0]) begin
            h0 = ch_reg[1];
            h1 = ch_reg[2];
        end else if (fault_reg[1]) begin
            h0 = ch_reg[0];
            h1 = ch_reg[2];
        end
        if (degraded_w) begin
            vote_next = h0;
            mism_next = (h0 != h1);
            unc_next  = (h0 != h1);
        end else begin
            vote_next = maj;
            mism_next = (ch_reg[0] != ch_reg[1]) || (ch_reg[1] != ch_reg[2]);
            unc_next  = 1'b0;
        end
    end

    // Stage 2 and health state; clr only touches the health state.
    always_ff @(posedge clock) begin
        if (reset) begin
            vote_reg      <= '0;
            out_valid_reg <= 1'b0;
            mismatch_reg  <= 1'b0;
            unc_reg       <= 1'b0;
            fault_reg     <= '0;
            err_reg       <= '0;
            for (int i = 0; i < 3; i++) streak_reg[i] <= '0;
        end else begin
            out_valid_reg <= v1_reg;
            if (v1_reg) begin
                vote_reg     <= vote_next;
                mismatch_reg <= mism_next;
                unc_reg      <= unc_next;
            end
            if (bus.clr) begin
                fault_reg <= '0;
                err_reg   <= '0;
                for (int i = 0; i < 3; i++) streak_reg[i] <= '0;
            end else if (v1_reg) begin
                if (mism_next && (err_reg != {CNT_W{1'b1}}))
                    err_reg <= err_reg + CNT_W'(1);
                if (!degraded_w) begin
                    if (|reach) begin
                        fault_reg <= fail_sel;
                        for (int i = 0; i < 3; i++) streak_reg[i] <= '0;
                    end else begin
                        for (int i = 0; i < 3; i++)
                            streak_reg[i] <= dissent[i] ? streak_inc[i] : '0;
                    end
                end
            end
        end
    end

    assign bus.vote_out      = vote_reg;
    assign bus.out_valid     = out_valid_reg;
    assign bus.mismatch      = mismatch_reg;
    assign bus.uncorrectable = unc_reg;
    assign bus.fault_ch      = fault_reg;
    assign bus.degraded      = degraded_w;
    assign bus.err_count     = err_reg;
endmodule

// File: tb/tb_tmr_voter_scrub.sv
// Scoreboard bench for tmr_voter_scrub: a default instance checked against a
// reference model, plus a CNT_W=2 instance for saturation and clear.
module tb_tmr_voter_scrub;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    tmr_voter_scrub_if #(.WIDTH(8), .CNT_W(8)) bus0 ();
    tmr_voter_scrub_if #(.WIDTH(8), .CNT_W(2)) bus1 ();

    tmr_voter_scrub #(.WIDTH(8), .CNT_W(8), .PERSIST(4)) dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (bus0.slave)
    );

    tmr_voter_scrub #(.WIDTH(8), .CNT_W(2), .PERSIST(4)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1.slave)
    );

    typedef struct {
        logic [7:0] vote;
        logic       mism;
        logic       unc;
        logic [2:0] fault;
        logic [7:0] err;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state for dut0
    logic [2:0] m_fault = '0;
    int         m_streak [3] = '{0, 0, 0};
    int         m_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic model_push(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        exp_t       e;
        logic [7:0] ch [3];
        logic [7:0] p0, p1;
        ch[0] = a; ch[1] = b; ch[2] = c;
        if (m_fault == 3'b000) begin
            e.vote = (a & b) | (b & c) | (a & c);
            e.mism = !((a == b) && (b == c));
            e.unc  = 1'b0;
            for (int i = 0; i < 3; i++)
                m_streak[i] = (ch[i] != e.vote) ? m_streak[i] + 1 : 0;
            for (int i = 0; i < 3; i++) begin
                if (m_fault == 3'b000 && m_streak[i] == 4) m_fault[i] = 1'b1;
            end
            if (m_fault != 3'b000) m_streak = '{0, 0, 0};
        end else begin
            p0 = m_fault[0] ? b : a;
            p1 = m_fault[2] ? b : c;
            e.vote = p0;
            e.mism = (p0 != p1);
            e.unc  = (p0 != p1);
        end
        if (e.mism && m_err < 255) m_err++;
        e.fault = m_fault;
        e.err   = 8'(m_err);
        exp_q.push_back(e);
    endtask

    task automatic drive0(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                          input logic v, input logic track);
        @(negedge clock);
        bus0.a_in = a; bus0.b_in = b; bus0.c_in = c; bus0.in_valid = v;
        if (v && track) model_push(a, b, c);
    endtask

    task automatic drive1(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                          input logic v, input logic cl);
        @(negedge clock);
        bus1.a_in = a; bus1.b_in = b; bus1.c_in = c; bus1.in_valid = v; bus1.clr = cl;
    endtask

    // Monitor: every dut0 output beat must match the oldest scoreboard entry.
    always @(negedge clock) begin
        exp_t e;
        if (!reset && bus0.out_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_out_valid", 32'(bus0.out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                $display("t=%0t vote=%02h mism=%0b unc=%0b fault=%03b err=%0d", $time,
                         bus0.vote_out, bus0.mismatch, bus0.uncorrectable, bus0.fault_ch, bus0.err_count);
                check_eq("vote_out", 32'(bus0.vote_out), 32'(e.vote));
                check_eq("mismatch", 32'(bus0.mismatch), 32'(e.mism));
                check_eq("uncorrectable", 32'(bus0.uncorrectable), 32'(e.unc));
                check_eq("fault_ch", 32'(bus0.fault_ch), 32'(e.fault));
                check_eq("degraded", 32'(bus0.degraded), 32'(|e.fault));
                check_eq("err_count", 32'(bus0.err_count), 32'(e.err));
            end
        end
    end

    initial begin
        bus0.a_in = '0; bus0.b_in = '0; bus0.c_in = '0; bus0.in_valid = 1'b0; bus0.clr = 1'b0;
        bus1.a_in = '0; bus1.b_in = '0; bus1.c_in = '0; bus1.in_valid = 1'b0; bus1.clr = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check_eq("rst_out_valid", 32'(bus0.out_valid), 32'd0);
        check_eq("rst_vote", 32'(bus0.vote_out), 32'd0);
        check_eq("rst_fault", 32'(bus0.fault_ch), 32'd0);
        check_eq("rst_err", 32'(bus0.err_count), 32'd0);

        // Single clean sample
        drive0(8'h5A, 8'h5A, 8'h5A, 1'b1, 1'b1);
        repeat (3) drive0(8'h00, 8'h00, 8'h00, 1'b0, 1'b1);

        // C dissents 3x, recovers, then dissents 4x and fails
        repeat (3) drive0(8'h33, 8'h33, 8'h00, 1'b1, 1'b1);
        drive0(8'h33, 8'h33, 8'h33, 1'b1, 1'b1);
        repeat (4) drive0(8'h33, 8'h33, 8'h00, 1'b1, 1'b1);
        repeat (2) drive0(8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
        check_eq("c_fail_fault", 32'(bus0.fault_ch), 32'h4);
        check_eq("c_fail_err", 32'(bus0.err_count), 32'd7);

        // Degraded: A vs B compare
        drive0(8'h33, 8'h34, 8'h00, 1'b1, 1'b1);
        drive0(8'h34, 8'h34, 8'hFF, 1'b1, 1'b1);
        repeat (2) drive0(8'h00, 8'h00, 8'h00, 1'b0, 1'b1);

        // Clear health state with the pipeline drained
        @(negedge clock);
        bus0.clr = 1'b1;
        m_fault = '0; m_streak = '{0, 0, 0}; m_err = 0;
        @(negedge clock);
        bus0.clr = 1'b0;
        check_eq("clr_fault", 32'(bus0.fault_ch), 32'd0);
        check_eq("clr_err", 32'(bus0.err_count), 32'd0);

        // B and C tie at PERSIST across invalid gaps; only B fails
        for (int i = 0; i < 4; i++) begin
            drive0(8'hFF, 8'h0F, 8'hF0, 1'b1, 1'b1);
            drive0(8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
        end
        drive0(8'hAA, 8'h00, 8'hAA, 1'b1, 1'b1);
        repeat (2) drive0(8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
        check_eq("tie_fault", 32'(bus0.fault_ch), 32'h2);

        // CNT_W=2 instance: saturation then clr racing a mismatch
        repeat (4) drive1(8'h01, 8'h00, 8'h00, 1'b1, 1'b0);
        drive1(8'h00, 8'h01, 8'h02, 1'b1, 1'b0);
        drive1(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clock);
        check_eq("sat_err", 32'(bus1.err_count), 32'd3);
        check_eq("sat_fault", 32'(bus1.fault_ch), 32'h1);
        drive1(8'h00, 8'h05, 8'h06, 1'b1, 1'b0);
        drive1(8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
        @(negedge clock);
        check_eq("clr_race_err", 32'(bus1.err_count), 32'd0);
        check_eq("clr_race_fault", 32'(bus1.fault_ch), 32'd0);
        check_eq("clr_race_valid", 32'(bus1.out_valid), 32'd1);
        check_eq("clr_race_vote", 32'(bus1.vote_out), 32'h05);
        check_eq("clr_race_mism", 32'(bus1.mismatch), 32'd1);
        bus1.clr = 1'b0;

        // Reset with samples in flight: nothing may emerge
        drive0(8'h11, 8'h11, 8'h11, 1'b1, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        bus0.a_in = 8'h22; bus0.b_in = 8'h22; bus0.c_in = 8'h22;
        @(negedge clock);
        check_eq("rst_mid_valid", 32'(bus0.out_valid), 32'd0);
        check_eq("rst_mid_vote", 32'(bus0.vote_out), 32'd0);
        check_eq("rst_mid_err", 32'(bus0.err_count), 32'd0);
        check_eq("rst_mid_fault", 32'(bus0.fault_ch), 32'd0);
        reset = 1'b0;
        bus0.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check_eq("post_rst_valid", 32'(bus0.out_valid), 32'd0);
        end

        check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/tmr_voter_scrub.md
# tmr_voter_scrub

Parametrised triple-modular-redundancy voter for WIDTH-bit buses, the successor to the single-bit 2-of-3 voter in the TMR path. It registers three redundant channels, produces a bitwise majority vote, and counts disagreements. It also tracks each channel's persistent dissent and, once a channel is declared failed, excludes it and falls back to two-channel compare. It sits between the replicated logic copies and the downstream consumer; fault flags and counters feed the health/status logic.

## Interface
- WIDTH, 8: bits per channel.
- CNT_W, 8: width of the saturating mismatch counter.
- PERSIST, 4: consecutive dissenting valid samples before a channel is declared failed; must be ≥1.

- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- a_in  in  WIDTH  channel A (index 0).
- b_in  in  WIDTH  channel B (index 1).
- c_in  in  WIDTH  channel C (index 2).
- in_valid  in  1  channels valid this cycle.
- clr  in  1  synchronous clear of err_count, dissent streaks and fault_ch.
- vote_out  out  WIDTH  voted result.
- out_valid  out  1  vote_out and status are valid.
- mismatch  out  1  active channels disagreed in the sample.
- uncorrectable  out  1  degraded mode and the two healthy channels disagreed.
- fault_ch  out  3  latched failed-channel flags {C,B,A}; at most one bit set.
- degraded  out  1  OR of fault_ch.
- err_count  out  CNT_W  number of valid samples with mismatch=1, saturating.

## Operation
- Stage 1: when in_valid=1, register a/b/c and the valid bit. When in_valid=0, the valid bit is registered as 0 and the data registers hold.
- Stage 2 registers the vote result and status only when the stage-1 valid bit is 1. out_valid follows the stage-1 valid bit; other outputs hold otherwise.
- Normal mode (fault_ch=0):
  - vote = (a&b)|(b&c)|(a&c), bitwise.
  - mismatch = any bit of a, b, c differs.
  - uncorrectable = 0.
  - Channel X dissents if X≠vote in any bit.
- Streaks: one per channel, width clog2(PERSIST+1).
  - On each valid stage-2 sample in normal mode: a dissenting channel's streak increments; a non-dissenting channel's streak resets to 0.
  - Streaks hold on invalid cycles, so gaps do not break a streak.
  - When a streak reaches PERSIST, the matching fault_ch bit sets at that same edge.
  - Tie: if several streaks reach PERSIST on the same edge, only the lowest index fails. All streaks clear at that edge.
- Degraded mode (one fault_ch bit set):
  - vote = lower-index healthy channel.
  - mismatch = uncorrectable = the two healthy channels differ.
  - Streaks are frozen at 0 and no further channel can fail.
- fault_ch stays latched until clr or reset.
- err_count increments by 1 per valid sample with mismatch=1 and saturates at 2^CNT_W−1.
- clr:
  - Clears err_count, streaks and fault_ch at the next edge.
  - Wins over a same-edge increment or failure; the result is 0.
  - Does not affect pipeline data, out_valid or vote_out.
- Reset values: all outputs 0, all stage registers 0, streaks 0.

## Timing
- Latency is 2 edges. Inputs sampled at edge k with in_valid=1 appear on vote_out/out_valid/mismatch/uncorrectable after edge k+1.
- err_count, streaks and fault_ch update at that same edge k+1. The vote at edge k+1 uses the mode in force before the edge; a newly set fault bit affects the next sample.
- Throughput is 1 sample per cycle; there is no backpressure.
- Reset mid-operation: in-flight samples are discarded. out_valid=0 from the edge after reset is sampled, until 2 edges after the next in_valid.

## Test plan
- Reset; then a=b=c=0x5A with one in_valid pulse → out_valid pulses once, 2 edges later; vote_out=0x5A, mismatch=0, err_count=0.
- a=0x33, b=0x33, c=0x00 for 3 valid samples, then all equal at 0x33, then c=0x00 for 4 samples → vote 0x33 throughout. err_count=7. fault_ch=3'b100 appears only at the 4th dissent of the second run.
- Continuing the previous scenario in degraded mode: a=0x33, b=0x34 → vote_out=0x33, uncorrectable=1, mismatch=1. Then a=b=0x34, c=0xFF → vote 0x34, mismatch=0.
- a=0xFF, b=0x0F, c=0xF0 for 4 consecutive valid samples with in_valid=0 gaps between them → vote 0xFF each sample. B and C both reach PERSIST on the same edge; only fault_ch=3'b010 sets.
- CNT_W=2: 5 mismatching samples → err_count saturates at 3. Assert clr on the same edge as a 6th mismatch → err_count=0, fault_ch=0.
- Assert reset while 2 samples are in flight → out_valid stays 0; vote_out=0; all counters and flags are 0 on the edge after reset.
